// File: rtl/rj_mem_ctrl.sv
// rj_mem_ctrl: arbitrates the shared 16x16 coefficient/data memory between the
// serial loader (write), the filter engine (read) and a full clear sweep.
// The memory's level handshake is turned into single-cycle grant/valid/done pulses.
module rj_mem_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              Sclk,
    input  logic              Reset_n,
    input  logic              clr_Req,
    input  logic              wr_Req,
    input  logic [ADDR_W-1:0] wr_Addr,
    input  logic [DATA_W-1:0] wr_Data,
    input  logic              rd_Req,
    input  logic [ADDR_W-1:0] rd_Addr,
    output logic              wr_Gnt,
    output logic              rd_Valid,
    output logic [DATA_W-1:0] rd_Data,
    output logic              clr_Done,
    output logic              busy,
    output logic              err,
    output logic              mem_start,
    output logic              mem_en,
    output logic              mem_cntrl_rst,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_wr_Addr,
    output logic [ADDR_W-1:0] mem_rd_Addr,
    output logic [DATA_W-1:0] mem_data_In,
    input  logic              mem_w_Done,
    input  logic              mem_data_Valid,
    input  logic [DATA_W-1:0] mem_data_Out
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ACCESS, S_RELEASE, S_CLR_NEXT} state_t;
    typedef enum logic [1:0] {OP_WR, OP_RD, OP_CLR} op_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    // Abort fires on the last permitted cycle so the handshake gets TIMEOUT cycles in a state.
    localparam logic [3:0]        TMO_LAST  = 4'(TIMEOUT - 1);

    state_t     state;
    op_t        op;
    logic       last_wr;    // 1: write was granted last, so a read wins the next tie
    logic [3:0] tmo_cnt;
    logic       ack;

    // Write and clear are acknowledged by w_Done, reads by data_Valid.
    assign ack = (op == OP_RD) ? mem_data_Valid : mem_w_Done;

    // Controller FSM; all outputs registered. Mode bits change only in IDLE/CLR_NEXT.
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= S_INIT;
            op            <= OP_WR;
            last_wr       <= 1'b0;
            tmo_cnt       <= '0;
            wr_Gnt        <= 1'b0;
            rd_Valid      <= 1'b0;
            rd_Data       <= '0;
            clr_Done      <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            mem_start     <= 1'b0;
            mem_en        <= 1'b0;
            mem_cntrl_rst <= 1'b0;
            mem_wr        <= 1'b0;
            mem_wr_Addr   <= '0;
            mem_rd_Addr   <= '0;
            mem_data_In   <= '0;
        end else begin
            wr_Gnt    <= 1'b0;
            rd_Valid  <= 1'b0;
            clr_Done  <= 1'b0;
            mem_start <= 1'b0;
            case (state)
                S_INIT: begin
                    mem_start <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (clr_Req) begin
                        op            <= OP_CLR;
                        mem_cntrl_rst <= 1'b1;
                        mem_wr        <= 1'b0;
                        mem_wr_Addr   <= '0;
                        mem_data_In   <= '0;
                        mem_en        <= 1'b1;
                        busy          <= 1'b1;
                        state         <= S_ACCESS;
                    end else if (wr_Req && (!rd_Req || !last_wr)) begin
                        op            <= OP_WR;
                        mem_cntrl_rst <= 1'b0;
                        mem_wr        <= 1'b1;
                        mem_wr_Addr   <= wr_Addr;
                        mem_data_In   <= wr_Data;
                        mem_en        <= 1'b1;
                        busy          <= 1'b1;
                        last_wr       <= 1'b1;
                        state         <= S_ACCESS;
                    end else if (rd_Req) begin
                        op            <= OP_RD;
                        mem_cntrl_rst <= 1'b0;
                        mem_wr        <= 1'b0;
                        mem_rd_Addr   <= rd_Addr;
                        mem_en        <= 1'b1;
                        busy          <= 1'b1;
                        last_wr       <= 1'b0;
                        state         <= S_ACCESS;
                    end else begin
                        // Park the mode bits once nothing is pending (also tidies up after an abort).
                        mem_cntrl_rst <= 1'b0;
                        mem_wr        <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (ack) begin
                        if (op == OP_RD)
                            rd_Data <= mem_data_Out;
                        mem_en  <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_RELEASE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err    <= 1'b1;
                        mem_en <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                S_RELEASE: begin
                    if (!ack) begin
                        tmo_cnt <= '0;
                        if (op == OP_WR) begin
                            wr_Gnt <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_IDLE;
                        end else if (op == OP_RD) begin
                            rd_Valid <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            // Done pulse is visible during the final CLR_NEXT cycle.
                            clr_Done <= (mem_wr_Addr == LAST_ADDR);
                            state    <= S_CLR_NEXT;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                S_CLR_NEXT: begin
                    if (mem_wr_Addr == LAST_ADDR) begin
                        mem_cntrl_rst <= 1'b0;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        mem_wr_Addr <= mem_wr_Addr + ADDR_ONE;
                        mem_en      <= 1'b1;
                        state       <= S_ACCESS;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_rj_mem_ctrl.sv
// Bench for rj_mem_ctrl: behavioural memory with combinational acknowledges,
// reference contents array and round-robin expectation kept at transaction level.
module tb_rj_mem_ctrl;

    logic        Sclk, Reset_n;
    logic        clr_Req, wr_Req, rd_Req;
    logic [3:0]  wr_Addr, rd_Addr;
    logic [15:0] wr_Data;
    logic        wr_Gnt, rd_Valid, clr_Done, busy, err;
    logic [15:0] rd_Data;
    logic        mem_start, mem_en, mem_cntrl_rst, mem_wr;
    logic [3:0]  mem_wr_Addr, mem_rd_Addr;
    logic [15:0] mem_data_In;
    logic        mem_w_Done, mem_data_Valid;
    logic [15:0] mem_data_Out;

    rj_mem_ctrl #(.ADDR_W(4), .DATA_W(16), .TIMEOUT(15)) dut (
        .Sclk(Sclk), .Reset_n(Reset_n), .clr_Req(clr_Req),
        .wr_Req(wr_Req), .wr_Addr(wr_Addr), .wr_Data(wr_Data),
        .rd_Req(rd_Req), .rd_Addr(rd_Addr),
        .wr_Gnt(wr_Gnt), .rd_Valid(rd_Valid), .rd_Data(rd_Data),
        .clr_Done(clr_Done), .busy(busy), .err(err),
        .mem_start(mem_start), .mem_en(mem_en), .mem_cntrl_rst(mem_cntrl_rst),
        .mem_wr(mem_wr), .mem_wr_Addr(mem_wr_Addr), .mem_rd_Addr(mem_rd_Addr),
        .mem_data_In(mem_data_In), .mem_w_Done(mem_w_Done),
        .mem_data_Valid(mem_data_Valid), .mem_data_Out(mem_data_Out)
    );

    initial Sclk = 1'b0;
    always #5 Sclk = ~Sclk;

    // Behavioural level-triggered memory; stall_wr withholds the write acknowledge.
    logic [15:0] mem [16];
    logic        stall_wr;
    assign mem_w_Done     = mem_en & (mem_wr | mem_cntrl_rst) & ~stall_wr;
    assign mem_data_Valid = mem_en & ~mem_wr & ~mem_cntrl_rst;
    assign mem_data_Out   = mem[mem_rd_Addr];
    always @(posedge Sclk)
        if (mem_en && mem_w_Done)
            mem[mem_wr_Addr] <= mem_cntrl_rst ? 16'h0000 : mem_data_In;

    logic [48:0] all_outs;
    assign all_outs = {wr_Gnt, rd_Valid, rd_Data, clr_Done, busy, err, mem_start, mem_en,
                       mem_cntrl_rst, mem_wr, mem_wr_Addr, mem_rd_Addr, mem_data_In};

    // Reference model state
    logic [15:0] ref_mem [16];
    bit          last_was_wr;
    int          errors, checks;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Write transaction from a negedge; lat = negedges until wr_Gnt, -1 if none.
    task automatic do_write(input logic [3:0] a, input logic [15:0] d, output int lat);
        wr_Addr = a; wr_Data = d; wr_Req = 1'b1; lat = -1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge Sclk);
            if (wr_Gnt) begin lat = n; break; end
        end
        wr_Req = 1'b0;
        if (lat > 0) begin ref_mem[a] = d; last_was_wr = 1'b1; end
    endtask

    task automatic do_read(input logic [3:0] a, output logic [15:0] q, output int lat);
        rd_Addr = a; rd_Req = 1'b1; lat = -1; q = 16'hxxxx;
        for (int n = 1; n <= 80; n++) begin
            @(negedge Sclk);
            if (rd_Valid) begin lat = n; q = rd_Data; break; end
        end
        rd_Req = 1'b0;
        if (lat > 0) last_was_wr = 1'b0;
    endtask

    // Pulse clr_Req and wait for clr_Done; reports latency and address sweep order.
    task automatic do_clear(output int lat, output bit order_ok, output int first_addr);
        int exp_a;
        exp_a = 0; order_ok = 1'b1; first_addr = -1; lat = -1;
        clr_Req = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge Sclk);
            clr_Req = 1'b0;
            if (mem_en) begin
                if (first_addr < 0) first_addr = int'(mem_wr_Addr);
                if (int'(mem_wr_Addr) != exp_a || !mem_cntrl_rst || mem_wr) order_ok = 1'b0;
                exp_a++;
            end
            if (clr_Done) begin lat = n; break; end
        end
        if (exp_a != 16) order_ok = 1'b0;
        @(negedge Sclk);
        if (lat > 0) for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge Sclk);
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL reset_outs: got %h expected 0", all_outs); end
        Reset_n = 1'b1;
        @(negedge Sclk);
        checks++;
        if (mem_start !== 1'b1) begin errors++; $display("FAIL init_start: got %b expected 1", mem_start); end
        @(negedge Sclk);
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL idle_outs: got %h expected 0", all_outs); end
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] q;
        logic [3:0] addrs [6];
        do_write(4'h3, 16'hA5C3, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
        do_read(4'h3, q, lat);
        checks++;
        if (lat != 3 || q !== 16'hA5C3) begin errors++; $display("FAIL rd_a5c3: got lat %0d data %h expected lat 3 data a5c3", lat, q); end
        for (int i = 0; i < 6; i++) begin
            addrs[i] = 4'($urandom_range(15));
            do_write(addrs[i], 16'($urandom), lat);
            checks++;
            if (lat != 3) begin errors++; $display("FAIL rand_wr_lat: got %0d expected 3", lat); end
        end
        for (int i = 0; i < 6; i++) begin
            do_read(addrs[i], q, lat);
            checks++;
            if (lat != 3 || q !== ref_mem[addrs[i]]) begin
                errors++; $display("FAIL rand_rd: addr %0d got %h lat %0d expected %h lat 3", addrs[i], q, lat, ref_mem[addrs[i]]);
            end
        end
    endtask

    task automatic test_round_robin();
        int grants, seq_bad, data_bad;
        logic [3:0] wa, ra;
        logic [15:0] wd;
        bit exp_wr;
        grants = 0; seq_bad = 0; data_bad = 0;
        wa = 4'($urandom_range(15)); wd = 16'($urandom); ra = 4'h3;
        wr_Addr = wa; wr_Data = wd; rd_Addr = ra;
        wr_Req = 1'b1; rd_Req = 1'b1;
        for (int n = 0; n < 200 && grants < 4; n++) begin
            @(negedge Sclk);
            if (wr_Gnt || rd_Valid) begin
                exp_wr = !last_was_wr;
                if (wr_Gnt && rd_Valid) seq_bad++;
                else if (wr_Gnt !== exp_wr) seq_bad++;
                if (wr_Gnt) begin
                    ref_mem[wa] = wd; last_was_wr = 1'b1;
                    wd = 16'($urandom); wr_Data = wd;
                end else begin
                    if (rd_Data !== ref_mem[ra]) data_bad++;
                    last_was_wr = 1'b0;
                end
                grants++;
            end
        end
        wr_Req = 1'b0; rd_Req = 1'b0;
        checks++;
        if (grants != 4) begin errors++; $display("FAIL rr_grants: got %0d expected 4", grants); end
        checks++;
        if (seq_bad != 0) begin errors++; $display("FAIL rr_order: got %0d bad grants expected 0", seq_bad); end
        checks++;
        if (data_bad != 0) begin errors++; $display("FAIL rr_rd_data: got %0d bad reads expected 0", data_bad); end
    endtask

    task automatic test_clear();
        int lat, first, bad_lat, bad_data; bit order_ok; logic [15:0] q;
        bad_lat = 0; bad_data = 0;
        for (int a = 0; a < 16; a++) begin
            do_write(4'(a), 16'hFFFF, lat);
            if (lat != 3) bad_lat++;
        end
        checks++;
        if (bad_lat != 0) begin errors++; $display("FAIL preload: got %0d slow writes expected 0", bad_lat); end
        do_clear(lat, order_ok, first);
        checks++;
        if (lat != 48) begin errors++; $display("FAIL clr_latency: got %0d expected 48", lat); end
        checks++;
        if (!order_ok) begin errors++; $display("FAIL clr_sweep: got out-of-order sweep expected 0..15"); end
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), q, lat);
            if (lat != 3 || q !== ref_mem[a]) bad_data++;
        end
        checks++;
        if (bad_data != 0) begin errors++; $display("FAIL clr_readback: got %0d nonzero/failed reads expected 0", bad_data); end
    endtask

    task automatic test_timeout();
        int en_cnt, lat; bit gnt_seen, seen_en; logic [15:0] q;
        en_cnt = 0; gnt_seen = 0; seen_en = 0;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_pre: got %b expected 0", err); end
        stall_wr = 1'b1;
        wr_Addr = 4'h5; wr_Data = 16'($urandom); wr_Req = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge Sclk);
            if (wr_Gnt) gnt_seen = 1'b1;
            if (mem_en) begin en_cnt++; seen_en = 1'b1; end
            else if (seen_en) break;
        end
        wr_Req = 1'b0; stall_wr = 1'b0;
        checks++;
        if (en_cnt != 15) begin errors++; $display("FAIL tmo_en_cycles: got %0d expected 15", en_cnt); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", err); end
        checks++;
        if (gnt_seen) begin errors++; $display("FAIL tmo_gnt: got 1 expected 0"); end
        do_read(4'h5, q, lat);
        checks++;
        if (lat != 3 || q !== ref_mem[5]) begin errors++; $display("FAIL tmo_read: got %h lat %0d expected %h lat 3", q, lat, ref_mem[5]); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_reset_mid_sweep();
        bit found; int lat, first; bit order_ok; logic [15:0] q;
        found = 0;
        clr_Req = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge Sclk);
            clr_Req = 1'b0;
            if (mem_en && mem_wr_Addr == 4'h7) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL sweep_addr7: got not reached expected reached"); end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL async_reset: got %h expected 0", all_outs); end
        repeat (2) @(negedge Sclk);
        Reset_n = 1'b1;
        @(negedge Sclk);
        checks++;
        if (mem_start !== 1'b1) begin errors++; $display("FAIL reinit_start: got %b expected 1", mem_start); end
        @(negedge Sclk);
        checks++;
        if (mem_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reinit_idle: got start %b busy %b expected 0 0", mem_start, busy); end
        do_clear(lat, order_ok, first);
        checks++;
        if (first != 0) begin errors++; $display("FAIL resweep_start: got %0d expected 0", first); end
        checks++;
        if (lat != 48 || !order_ok) begin errors++; $display("FAIL resweep: got lat %0d order_ok %0d expected 48 1", lat, order_ok); end
        do_read(4'($urandom_range(15)), q, lat);
        checks++;
        if (lat != 3 || q !== 16'h0000) begin errors++; $display("FAIL resweep_read: got %h lat %0d expected 0000 lat 3", q, lat); end
    endtask

    initial begin
        errors = 0; checks = 0; last_was_wr = 1'b0;
        clr_Req = 0; wr_Req = 0; rd_Req = 0; wr_Addr = 0; rd_Addr = 0; wr_Data = 0;
        stall_wr = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
        test_reset();
        test_write_read();
        test_round_robin();
        test_clear();
        test_timeout();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
